// File: rtl/phase_sched_pkg.sv
// Shared definitions for the phase scheduler: state encodings, default
// timing constants, selector width and a counter-width helper.
package phase_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  localparam int DIV_DEF     = 4;
  localparam int OS_DEF      = 4;
  localparam int FILL_DEF    = 4;
  localparam int ROT_SYM_DEF = 1024;
  localparam int SEL_W       = 2;

  // Width of a counter spanning 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/phase_sched_tick.sv
// Clock divider: counts 0..DIV-1 while enabled and flags the last count
// as the datapath enable tick. Held at zero whenever disabled.
module tick_div
  import phase_sched_pkg::*;
#(
  parameter int DIV = DIV_DEF
) (
  input  logic clock,
  input  logic i_reset,
  input  logic count_en,
  output logic tick
);

  localparam int            DW       = cnt_w(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

  logic [DW-1:0] div_cnt_r;

  assign tick = count_en && (div_cnt_r == DIV_LAST);

  // Divider count: clear when disabled, wrap after the last count.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      div_cnt_r <= '0;
    end else if (!count_en) begin
      div_cnt_r <= '0;
    end else if (div_cnt_r == DIV_LAST) begin
      div_cnt_r <= '0;
    end else begin
      div_cnt_r <= div_cnt_r + DW'(1);
    end
  end

endmodule

// File: rtl/phase_sched.sv
// Timing controller for the receive FIR -> phase-select/slicer chain.
// Produces the datapath enable, the fill-qualified valid, the symbol strobe
// and the phase selector (fixed from switches or auto-rotating).
module phase_sched
  import phase_sched_pkg::*;
#(
  parameter int DIV     = DIV_DEF,
  parameter int OS      = OS_DEF,
  parameter int FILL    = FILL_DEF,
  parameter int ROT_SYM = ROT_SYM_DEF
) (
  input  logic             clock,
  input  logic             i_reset,
  input  logic             i_run,
  input  logic             i_mode,
  input  logic [SEL_W-1:0] i_phase,
  output logic             o_enable,
  output logic             o_valid,
  output logic [SEL_W-1:0] o_selector,
  output logic             o_sym_strobe,
  output logic             o_busy
);

  localparam int            FW        = cnt_w(FILL);
  localparam int            SW        = cnt_w(ROT_SYM);
  localparam logic [FW-1:0] FILL_LAST = FW'(FILL - 1);
  localparam logic [SW-1:0] ROT_LAST  = SW'(ROT_SYM - 1);
  localparam logic [1:0]    OS_LAST   = 2'(OS - 1);

  state_t        state_r;
  state_t        state_nx_s;
  logic          div_en_s;
  logic          tick_s;
  logic          bound_s;
  logic [1:0]    os_cnt_r;
  logic [FW-1:0] fill_cnt_r;
  logic [SW-1:0] sym_cnt_r;

  // The divider only runs while active and still commanded to run, so a
  // stop request suppresses the tick on the very edge it is seen.
  assign div_en_s = (state_r != ST_IDLE) && i_run;
  assign bound_s  = tick_s && (os_cnt_r == OS_LAST);

  tick_div #(
    .DIV (DIV)
  ) u_tick_div (
    .clock    (clock),
    .i_reset  (i_reset),
    .count_en (div_en_s),
    .tick     (tick_s)
  );

  // Next-state decode: stop always wins, fill completes on the FILL-th tick.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (i_run) state_nx_s = ST_FILL;
        else       state_nx_s = ST_IDLE;
      end
      ST_FILL: begin
        if (!i_run)                                  state_nx_s = ST_IDLE;
        else if (tick_s && (fill_cnt_r == FILL_LAST)) state_nx_s = ST_RUN;
        else                                         state_nx_s = ST_FILL;
      end
      ST_RUN: begin
        if (!i_run) state_nx_s = ST_IDLE;
        else        state_nx_s = ST_RUN;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clock) begin
    if (!i_reset) state_r <= ST_IDLE;
    else          state_r <= state_nx_s;
  end

  // Oversample and fill counters advance on enable ticks, cleared when idle.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      os_cnt_r   <= 2'd0;
      fill_cnt_r <= '0;
    end else if ((state_r == ST_IDLE) || !i_run) begin
      os_cnt_r   <= 2'd0;
      fill_cnt_r <= '0;
    end else begin
      if (tick_s) os_cnt_r <= os_cnt_r + 2'd1;
      if (tick_s && (state_r == ST_FILL)) fill_cnt_r <= fill_cnt_r + FW'(1);
    end
  end

  // Registered timing outputs; valid trails entry into RUN by one cycle.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      o_enable     <= 1'b0;
      o_sym_strobe <= 1'b0;
      o_valid      <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_enable     <= tick_s;
      o_sym_strobe <= bound_s;
      o_valid      <= (state_r == ST_RUN) && i_run;
      o_busy       <= (state_nx_s != ST_IDLE);
    end
  end

  // Selector and rotation count update on the cycle after a symbol boundary,
  // so the selector can never move inside a symbol. A stop keeps the selector.
  always_ff @(posedge clock) begin
    if (!i_reset) begin
      o_selector <= '0;
      sym_cnt_r  <= '0;
    end else begin
      if ((state_r == ST_IDLE) || !i_run || !i_mode) begin
        sym_cnt_r <= '0;
      end else if (o_sym_strobe) begin
        if (sym_cnt_r == ROT_LAST) sym_cnt_r <= '0;
        else                       sym_cnt_r <= sym_cnt_r + SW'(1);
      end
      if (o_sym_strobe && i_run) begin
        if (!i_mode)                    o_selector <= i_phase;
        else if (sym_cnt_r == ROT_LAST) o_selector <= o_selector + SEL_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_phase_sched.sv
// Self-checking bench for phase_sched: two instances (DIV=4 and DIV=1, both
// with ROT_SYM=2). Expected outputs come from a model that counts cycles
// since the block went busy and are queued as each stimulus cycle is issued.
module tb_phase_sched;

  typedef struct packed {
    logic        busy;
    logic [31:0] k;
    logic [1:0]  sel;
    logic [31:0] sc;
    logic        en;
    logic        val;
    logic        stb;
  } mdl_t;

  localparam int ROT = 2;
  localparam int FIL = 4;

  logic       clock = 1'b0;
  logic       rst4, rst1, run, mode;
  logic [1:0] phase;
  logic       en4, val4, stb4, busy4;
  logic [1:0] sel4;
  logic       en1, val1, stb1, busy1;
  logic [1:0] sel1;

  int   n_chk  = 0;
  int   n_fail = 0;
  mdl_t m4, m1, e;
  mdl_t q4[$];
  mdl_t q1[$];
  logic found;

  always #5 clock = ~clock;

  phase_sched #(.DIV(4), .OS(4), .FILL(FIL), .ROT_SYM(ROT)) u_dut4 (
    .clock(clock), .i_reset(rst4), .i_run(run), .i_mode(mode), .i_phase(phase),
    .o_enable(en4), .o_valid(val4), .o_selector(sel4),
    .o_sym_strobe(stb4), .o_busy(busy4)
  );

  phase_sched #(.DIV(1), .OS(4), .FILL(FIL), .ROT_SYM(ROT)) u_dut1 (
    .clock(clock), .i_reset(rst1), .i_run(run), .i_mode(mode), .i_phase(phase),
    .o_enable(en1), .o_valid(val1), .o_selector(sel1),
    .o_sym_strobe(stb1), .o_busy(busy1)
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: k = cycles since busy rose; enables land on multiples
  // of div, a symbol is every 4th enable, valid follows the FILL-th enable.
  function automatic mdl_t mstep(input mdl_t m, input logic rst, input logic rn,
                                 input logic md, input logic [1:0] ph, input int div);
    mdl_t n;
    n = m;
    if (!rst) begin
      n = '0;
    end else if (!rn || !m.busy) begin
      n.busy = rn;
      n.k = 0; n.sc = 0; n.en = 1'b0; n.val = 1'b0; n.stb = 1'b0;
    end else begin
      if (m.stb) begin
        if (!md) n.sel = ph;
        else if (m.sc == 32'(ROT - 1)) begin n.sel = m.sel + 2'd1; n.sc = 0; end
        else n.sc = m.sc + 32'd1;
      end
      if (!md) n.sc = 0;
      n.k   = m.k + 32'd1;
      n.en  = ((n.k % div) == 0);
      n.stb = n.en && (((n.k / div) % 4) == 0);
      n.val = (n.k >= 32'(FIL * div + 1));
    end
    return n;
  endfunction

  // One clock: queue the expected outputs, advance, compare one edge later.
  task automatic cycle(input int n);
    for (int i = 0; i < n; i++) begin
      m4 = mstep(m4, rst4, run, mode, phase, 4);
      q4.push_back(m4);
      m1 = mstep(m1, rst1, run, mode, phase, 1);
      q1.push_back(m1);
      @(posedge clock);
      #1;
      e = q4.pop_front();
      chk_eq("en4",   32'(en4),   32'(e.en));
      chk_eq("val4",  32'(val4),  32'(e.val));
      chk_eq("stb4",  32'(stb4),  32'(e.stb));
      chk_eq("busy4", 32'(busy4), 32'(e.busy));
      chk_eq("sel4",  32'(sel4),  32'(e.sel));
      e = q1.pop_front();
      chk_eq("en1",   32'(en1),   32'(e.en));
      chk_eq("val1",  32'(val1),  32'(e.val));
      chk_eq("stb1",  32'(stb1),  32'(e.stb));
      chk_eq("busy1", 32'(busy1), 32'(e.busy));
      chk_eq("sel1",  32'(sel1),  32'(e.sel));
    end
  endtask

  initial begin
    m4 = '0; m1 = '0;
    rst4 = 1'b0; rst1 = 1'b0; run = 1'b1; mode = 1'b0; phase = 2'd0;
    #2;
    // Reset held with run requested.
    cycle(3);
    chk_eq("rst_busy", 32'(busy4), 32'd0);
    chk_eq("rst_en",   32'(en4),   32'd0);
    chk_eq("rst_sel",  32'(sel4),  32'd0);
    // Release: busy next cycle, first enable DIV cycles after that edge.
    rst4 = 1'b1; rst1 = 1'b1;
    cycle(1);
    chk_eq("rel_busy", 32'(busy4), 32'd1);
    cycle(3);
    chk_eq("pre_en", 32'(en4), 32'd0);
    cycle(1);
    chk_eq("first_en", 32'(en4), 32'd1);
    cycle(12);
    chk_eq("fill_val", 32'(val4), 32'd0);
    chk_eq("fill_stb", 32'(stb4), 32'd1);
    cycle(1);
    chk_eq("valid_rise", 32'(val4), 32'd1);
    // Fixed phase change mid-symbol: selector waits for the next boundary.
    found = 1'b0;
    for (int i = 0; i < 32 && !found; i++) begin
      if ((m4.k % 16) == 6) found = 1'b1;
      else cycle(1);
    end
    chk_eq("mid_sym_found", 32'(found), 32'd1);
    phase = 2'd2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      cycle(1);
      if (m4.stb) found = 1'b1;
    end
    chk_eq("bnd_found", 32'(found), 32'd1);
    chk_eq("sel_hold", 32'(sel4), 32'd0);
    cycle(1);
    chk_eq("sel_new", 32'(sel4), 32'd2);
    cycle(20);
    // Auto-rotate through all phases including the 3 -> 0 wrap.
    mode = 1'b1;
    cycle(200);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (m4.sel == 2'd3) found = 1'b1;
      else cycle(1);
    end
    chk_eq("sel3_found", 32'(found), 32'd1);
    cycle(3);
    // Stop with selector at 3: outputs clear, selector kept.
    run = 1'b0;
    cycle(1);
    chk_eq("stop_val",  32'(val4),  32'd0);
    chk_eq("stop_en",   32'(en4),   32'd0);
    chk_eq("stop_busy", 32'(busy4), 32'd0);
    chk_eq("stop_sel",  32'(sel4),  32'd3);
    cycle(3);
    // Restart: fill again before valid.
    run = 1'b1;
    cycle(17);
    chk_eq("re_fill_val", 32'(val4), 32'd0);
    chk_eq("re_sel",      32'(sel4), 32'd3);
    cycle(1);
    chk_eq("re_valid", 32'(val4), 32'd1);
    cycle(40);
    // DIV=1: enable every cycle; reset on a boundary blocks the update.
    mode = 1'b0; phase = 2'd1;
    cycle(20);
    chk_eq("d1_en", 32'(en1), 32'd1);
    phase = 2'd2;
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (m1.stb) found = 1'b1;
      else cycle(1);
    end
    chk_eq("d1_bnd_found", 32'(found), 32'd1);
    rst1 = 1'b0;
    cycle(1);
    chk_eq("d1_rst_sel",  32'(sel1),  32'd0);
    chk_eq("d1_rst_busy", 32'(busy1), 32'd0);
    rst1 = 1'b1;
    cycle(12);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
